fetch_phase: RTL and testbench
==============================

# fetch_phase

Front-end stage directly downstream of the write-back phase's PC queue. Each cycle it takes the instruction byte returned by instruction memory, tagged with the PC that `write_back_phase` presents on `pc_to_fet`. It appends the byte to a byte FIFO only when it is contiguous with the bytes already held, and exposes a window of head bytes to the decoder. It generates `stall_pc` when the FIFO is full and discards all state on `flush`.

## Interface
- `LOAD_LATENCY`, 1 — instruction-memory read latency in cycles; must match `write_back_phase`.
- `FQ_DEPTH`, 16 — byte FIFO depth; power of two, ≥ `WIN`.
- `WIN`, 8 — decode window width in bytes.
- `clk` in 1 — clock.
- `rstn` in 1 — reset, synchronous, active-low.
- `inst_byte` in 8 — byte read from instruction memory for address `pc_to_fet`.
- `pc_to_fet` in `ADDR_W` — address of `inst_byte` (from `pc_queue`).
- `flush` in 1 — discard request from `flush_control`; held for `LOAD_LATENCY` cycles.
- `stall_pc` out 1 — freezes the PC queue and rewinds RIP to `pc_to_fet`.
- `fd_bytes` out 8·`WIN` — head bytes; byte i at bits [8i+7:8i]; invalid lanes are 0.
- `fd_pc` out `ADDR_W` — PC of byte 0 of `fd_bytes`.
- `fd_avail` out clog2(`WIN`+1) — valid bytes in the window, min(count, `WIN`).
- `fd_consume` in clog2(`WIN`+1) — bytes retired by the decoder this cycle; must be ≤ `fd_avail`.

## Operation
- State machine `fs`:
  - WARM: entered on reset. A down-counter counts `LOAD_LATENCY` cycles. All bytes are dropped. Go to SYNC when the counter reaches 0.
  - SYNC: FIFO empty, no expected PC yet. On the first non-flush, non-stalled cycle, push the byte, set `head_pc` = `pc_to_fet` and `tail_pc` = `pc_to_fet`+1, and go to STREAM.
  - STREAM: push only if `pc_to_fet` == `tail_pc`, count < `FQ_DEPTH`, and `flush` = 0. On a push, `tail_pc` increments by 1. A non-contiguous byte is dropped silently; it is a replay after a stall.
- `stall_pc` = (count == `FQ_DEPTH`). It is driven from the registered count only, with no combinational path from `fd_consume`. A byte presented while `stall_pc` = 1 is dropped; RIP rewinds, so the byte is refetched.
- Pop: count −= `fd_consume`, head pointer += `fd_consume` mod `FQ_DEPTH`, and `head_pc` += `fd_consume`. A push and a pop in the same cycle are both applied: count' = count + push − `fd_consume`.
- Flush: any cycle with `flush` = 1 empties the FIFO, ignores both push and `fd_consume`, and forces SYNC. State stays in SYNC while `flush` is held. Flush overrides everything except reset.
- `fd_consume` > `fd_avail` is illegal: assertion in simulation; RTL clamps it to `fd_avail`.
- Arithmetic:
  - Pointers are log2(`FQ_DEPTH`) bits and wrap naturally.
  - PCs are `ADDR_W`-bit with modulo-2^`ADDR_W` wrap.
  - Count is clog2(`FQ_DEPTH`+1) bits.

## Timing
- Reset values:
  - `fs` = WARM (or SYNC if `LOAD_LATENCY` = 0).
  - count = 0, pointers = 0, `head_pc` = 0, `tail_pc` = 0.
  - Outputs: `stall_pc` = 0, `fd_avail` = 0, `fd_bytes` = 0, `fd_pc` = 0.
- A byte pushed in cycle t is visible on `fd_bytes`/`fd_avail` in cycle t+1. The FIFO is not bypassed.
- `fd_*` are combinational from registered FIFO state, so the decoder sees a stable window all cycle.
- `stall_pc` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop with no simultaneous push.
- Flush in cycle t: `fd_avail` = 0 from t+1. The first post-flush byte is accepted in the first cycle with `flush` = 0.
- Throughput: 1 byte/cycle in; up to `WIN` bytes/cycle out.

## Structure
- The shared package holds:
  - `addr_t` and `ADDR_W`, reused from common params.
  - A new `fetch_state_t` enum {WARM, SYNC, STREAM}.
  - A `fd_win_t` packed struct {bytes, pc, avail} for the decode-side port bundle.
- One sub-module, `byte_window_fifo`: storage array, pointers, count, multi-byte pop, and the `WIN`-lane read mux with zero fill. The contiguity check, the state machine and `stall_pc` stay in `fetch_phase`.

## Test plan
- Reset with `LOAD_LATENCY`=2:
  - Bytes 0xAA and 0xBB are presented in the first 2 cycles and are dropped.
  - Byte 0x48 @PC 0x100 in cycle 3 is accepted.
  - Next cycle: `fd_pc`=0x100, `fd_avail`=1, `fd_bytes`[7:0]=0x48.
- Feed 16 contiguous bytes 0x00–0x0F from PC 0x200 with `fd_consume`=0:
  - `stall_pc`=1 after the 16th push.
  - A 17th byte @0x210 is dropped.
  - With `fd_consume`=3: `fd_pc`=0x203 and `stall_pc`=0 the next cycle.
- In STREAM with `tail_pc`=0x305, present a byte @0x304 (replay):
  - Byte is dropped, count unchanged.
  - A byte @0x305 in the next cycle is accepted.
- Push and pop in the same cycle:
  - count=5, `fd_consume`=5, push @`tail_pc` → count=1, `fd_pc`=old+5.
- Flush while holding 7 bytes and `fd_consume`=4 in the same cycle:
  - `fd_avail`=0 next cycle; the pop is ignored.
  - After `flush` drops, byte @0x800 is accepted as the new head.
- Wrap: run 40 bytes through a 16-deep FIFO with mixed `fd_consume` values of 1–8:
  - Every `fd_bytes` lane matches a reference byte model.
  - PC wraps 0xFFFF_FFFF→0 with `ADDR_W`=32.

Source files
------------

// File: rtl/fetch_phase_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fetch_phase_pkg
// Brief  : Shared types for the fetch front end: address type, fetch state
//          encoding and the decode-side window bundle.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package fetch_phase_pkg;

  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    FS_WARM   = 2'd0,
    FS_SYNC   = 2'd1,
    FS_STREAM = 2'd2
  } fetch_state_t;

  localparam int FD_WIN     = 8;
  localparam int FD_AVAIL_W = $clog2(FD_WIN + 1);

  // Decode-side bundle for the default window width
  typedef struct packed {
    logic [8*FD_WIN-1:0]   bytes;
    addr_t                 pc;
    logic [FD_AVAIL_W-1:0] avail;
  } fd_win_t;

endpackage
`default_nettype wire

// File: rtl/fetch_phase_byte_window_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : byte_window_fifo
// Brief  : Byte FIFO with single-byte push, multi-byte pop and a WIN-lane
//          head window (lanes beyond the held count read as zero).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module byte_window_fifo #(
  parameter  int FQ_DEPTH = 16,
  parameter  int WIN      = 8,
  localparam int PTR_W    = $clog2(FQ_DEPTH),
  localparam int CNT_W    = $clog2(FQ_DEPTH + 1),
  localparam int AVAIL_W  = $clog2(WIN + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               push,
  input  logic [7:0]         push_byte,
  input  logic [AVAIL_W-1:0] pop_cnt,
  output logic [CNT_W-1:0]   count,
  output logic [8*WIN-1:0]   win_bytes,
  output logic [AVAIL_W-1:0] avail
);

  logic [7:0]       r_mem [FQ_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy bookkeeping; flush empties, otherwise push and pop combine
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(pop_cnt);
      r_count  <= r_count + CNT_W'(push) - CNT_W'(pop_cnt);
    end
  end

  // Byte storage; contents need no reset since unoccupied lanes are masked
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= push_byte;
    end
  end

  // Head window: lane i shows the i-th oldest byte, zero when not held
  for (genvar i = 0; i < WIN; i++) begin : g_lane
    logic [PTR_W-1:0] w_idx;
    assign w_idx = r_rd_ptr + PTR_W'(i);
    assign win_bytes[8*i +: 8] = (CNT_W'(i) < r_count) ? r_mem[w_idx] : 8'h00;
  end

  assign count = r_count;
  assign avail = (r_count >= CNT_W'(WIN)) ? AVAIL_W'(WIN) : AVAIL_W'(r_count);

endmodule
`default_nettype wire

// File: rtl/fetch_phase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fetch_phase
// Brief  : Accepts PC-tagged instruction bytes, keeps only the contiguous
//          stream in a byte FIFO and presents a head window to the decoder.
//          Stalls the PC queue when full and drops everything on flush.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module fetch_phase
  import fetch_phase_pkg::*;
#(
  parameter  int LOAD_LATENCY = 1,
  parameter  int FQ_DEPTH     = 16,
  parameter  int WIN          = 8,
  localparam int AVAIL_W      = $clog2(WIN + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         inst_byte,
  input  addr_t              pc_to_fet,
  input  logic               flush,
  output logic               stall_pc,
  output logic [8*WIN-1:0]   fd_bytes,
  output addr_t              fd_pc,
  output logic [AVAIL_W-1:0] fd_avail,
  input  logic [AVAIL_W-1:0] fd_consume
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int LAT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY + 1) : 1;
  localparam fetch_state_t FS_INIT = (LOAD_LATENCY == 0) ? FS_SYNC : FS_WARM;

  fetch_state_t       r_fs;
  logic [LAT_W-1:0]   r_warm_cnt;
  addr_t              r_head_pc;
  addr_t              r_tail_pc;
  logic [CNT_W-1:0]   w_count;
  logic               w_stall;
  logic               w_push;
  logic [AVAIL_W-1:0] w_pop;

  // Full FIFO freezes the PC queue; depends on registered occupancy only
  assign w_stall = (w_count == CNT_W'(FQ_DEPTH));

  // Never retire more than the window shows
  assign w_pop = (fd_consume > fd_avail) ? fd_avail : fd_consume;

  // Accept decision: first byte after sync, then only the expected next PC
  always_comb begin
    w_push = 1'b0;
    if (!flush) begin
      case (r_fs)
        FS_SYNC:   w_push = !w_stall;
        FS_STREAM: w_push = !w_stall && (pc_to_fet == r_tail_pc);
        default:   w_push = 1'b0;
      endcase
    end
  end

  // Fetch state machine with head/tail PC tracking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fs       <= FS_INIT;
      r_warm_cnt <= LAT_W'(LOAD_LATENCY);
      r_head_pc  <= '0;
      r_tail_pc  <= '0;
    end else if (flush) begin
      r_fs <= FS_SYNC;
    end else begin
      case (r_fs)
        FS_WARM: begin
          // Bytes returned before the first real fetch are stale
          if (r_warm_cnt <= LAT_W'(1)) begin
            r_warm_cnt <= '0;
            r_fs       <= FS_SYNC;
          end else begin
            r_warm_cnt <= r_warm_cnt - LAT_W'(1);
          end
        end
        FS_SYNC: begin
          if (w_push) begin
            r_head_pc <= pc_to_fet;
            r_tail_pc <= pc_to_fet + addr_t'(1);
            r_fs      <= FS_STREAM;
          end
        end
        FS_STREAM: begin
          if (w_push) begin
            r_tail_pc <= r_tail_pc + addr_t'(1);
          end
          r_head_pc <= r_head_pc + addr_t'(w_pop);
        end
        default: r_fs <= FS_SYNC;
      endcase
    end
  end

  byte_window_fifo #(
    .FQ_DEPTH (FQ_DEPTH),
    .WIN      (WIN)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (w_push),
    .push_byte (inst_byte),
    .pop_cnt   (w_pop),
    .count     (w_count),
    .win_bytes (fd_bytes),
    .avail     (fd_avail)
  );

  assign stall_pc = w_stall;
  assign fd_pc    = r_head_pc;

  // Decoder contract: retire no more than the visible window
  assert property (@(posedge clk) disable iff (!rstn || flush) fd_consume <= fd_avail);

endmodule
`default_nettype wire

// File: tb/tb_fetch_phase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_fetch_phase
// Brief  : Self-checking bench for fetch_phase: directed vector table, a
//          PC-wrap sequence and random traffic against a byte-queue model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_phase;
  import fetch_phase_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 16;
  localparam int W     = 8;
  localparam int AW    = $clog2(W + 1);

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [7:0]      inst_byte = 8'h00;
  addr_t           pc_to_fet = '0;
  logic            flush = 1'b0;
  logic            stall_pc;
  logic [8*W-1:0]  fd_bytes;
  addr_t           fd_pc;
  logic [AW-1:0]   fd_avail;
  logic [AW-1:0]   fd_consume = '0;

  fetch_phase #(
    .LOAD_LATENCY (LAT),
    .FQ_DEPTH     (DEPTH),
    .WIN          (W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .inst_byte  (inst_byte),
    .pc_to_fet  (pc_to_fet),
    .flush      (flush),
    .stall_pc   (stall_pc),
    .fd_bytes   (fd_bytes),
    .fd_pc      (fd_pc),
    .fd_avail   (fd_avail),
    .fd_consume (fd_consume)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain byte queue plus stream bookkeeping
  byte unsigned m_q[$];
  addr_t        m_head;
  addr_t        m_tail;
  int           m_warm;
  bit           m_synced;
  bit           m_last_push;

  function automatic int m_avail();
    return (m_q.size() < W) ? m_q.size() : W;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_head      = '0;
    m_tail      = '0;
    m_warm      = LAT;
    m_synced    = 1'b0;
    m_last_push = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] b, input addr_t pc, input bit fl, input int cons);
    bit full_before;
    full_before = (m_q.size() == DEPTH);
    m_last_push = 1'b0;
    if (fl) begin
      m_q.delete();
      m_synced = 1'b0;
      m_warm   = 0;
      return;
    end
    if (m_warm > 0) begin
      m_warm--;
      return;
    end
    m_last_push = !full_before && (!m_synced || pc == m_tail);
    for (int k = 0; k < cons; k++) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
    end
    m_head = m_head + addr_t'(cons);
    if (m_last_push) begin
      if (!m_synced) begin
        m_head   = pc;
        m_synced = 1'b1;
      end
      m_q.push_back(b);
      m_tail = pc + addr_t'(1);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [8*W-1:0] exp_b;
    int n;
    n     = m_avail();
    exp_b = '0;
    for (int k = 0; k < n; k++) exp_b[8*k +: 8] = m_q[k];
    chk("model_avail", 64'(fd_avail), 64'(n));
    chk("model_stall", 64'(stall_pc), 64'(m_q.size() == DEPTH));
    chk("model_bytes", 64'(fd_bytes), 64'(exp_b));
    if (n > 0) chk("model_pc", 64'(fd_pc), 64'(m_head));
  endtask

  // Caller is at a negedge; drive, let one posedge happen, check, return at next negedge
  task automatic cycle(input logic [7:0] b, input addr_t pc, input bit fl, input int cons);
    inst_byte  = b;
    pc_to_fet  = pc;
    flush      = fl;
    fd_consume = AW'(cons);
    @(posedge clk);
    model_step(b, pc, fl, cons);
    #1;
    check_model();
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    addr_t      pc;
    bit         fl;
    int         cons;
    int         e_avail;
    bit         e_stall;
    addr_t      e_pc;
    logic [7:0] e_b0;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic [7:0] b, input addr_t pc, input bit fl, input int cons,
                              input int e_avail, input bit e_stall, input addr_t e_pc, input logic [7:0] e_b0);
    vec_t v;
    v.b = b; v.pc = pc; v.fl = fl; v.cons = cons;
    v.e_avail = e_avail; v.e_stall = e_stall; v.e_pc = e_pc; v.e_b0 = e_b0;
    tv.push_back(v);
  endfunction

  initial begin
    addr_t p;
    int    accepted;
    bit    seen_high;
    bit    saw_wrap;
    int    flush_left;
    int    cons;
    int    r;
    addr_t pc;
    bit    fl;
    bit    light;

    // Directed table, expectations are the window after each cycle's clock edge
    add(8'hAA, 32'h000, 0, 0, 0, 0, 32'h0,   8'h00);   // warm-up drop
    add(8'hBB, 32'h001, 0, 0, 0, 0, 32'h0,   8'h00);   // warm-up drop
    add(8'h48, 32'h100, 0, 0, 1, 0, 32'h100, 8'h48);   // first accepted
    add(8'h00, 32'h000, 1, 0, 0, 0, 32'h0,   8'h00);
    add(8'h00, 32'h000, 1, 0, 0, 0, 32'h0,   8'h00);
    for (int k = 0; k < 16; k++)
      add(8'(k), 32'h200 + 32'(k), 0, 0, (k + 1 < W) ? k + 1 : W, k == 15, 32'h200, 8'h00);
    add(8'h10, 32'h210, 0, 0, 8, 1, 32'h200, 8'h00);   // 17th byte dropped
    add(8'h10, 32'h210, 0, 3, 8, 0, 32'h203, 8'h03);   // pop 3 releases stall
    add(8'h00, 32'h000, 1, 0, 0, 0, 32'h0,   8'h00);
    add(8'h00, 32'h000, 1, 0, 0, 0, 32'h0,   8'h00);
    for (int k = 0; k < 5; k++)
      add(8'h30 + 8'(k), 32'h300 + 32'(k), 0, 0, k + 1, 0, 32'h300, 8'h30);
    add(8'hEE, 32'h304, 0, 0, 5, 0, 32'h300, 8'h30);   // replay dropped
    add(8'h35, 32'h305, 0, 0, 6, 0, 32'h300, 8'h30);   // expected PC accepted
    add(8'h77, 32'h000, 0, 1, 5, 0, 32'h301, 8'h31);   // stray PC, pop 1
    add(8'h36, 32'h306, 0, 5, 1, 0, 32'h306, 8'h36);   // push+pop same cycle
    for (int k = 7; k < 13; k++)
      add(8'h30 + 8'(k), 32'h300 + 32'(k), 0, 0, k - 5, 0, 32'h306, 8'h36);
    add(8'h99, 32'h30D, 1, 4, 0, 0, 32'h0,   8'h00);   // flush beats pop and push
    add(8'h99, 32'h30D, 1, 0, 0, 0, 32'h0,   8'h00);
    add(8'hC3, 32'h800, 0, 0, 1, 0, 32'h800, 8'hC3);   // new head after flush

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", 64'(stall_pc), 64'h0);
    chk("reset_avail", 64'(fd_avail), 64'h0);
    chk("reset_bytes", 64'(fd_bytes), 64'h0);
    chk("reset_pc",    64'(fd_pc),    64'h0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      cycle(tv[i].b, tv[i].pc, tv[i].fl, tv[i].cons);
      chk($sformatf("vec%0d_avail", i), 64'(fd_avail),      64'(tv[i].e_avail));
      chk($sformatf("vec%0d_stall", i), 64'(stall_pc),      64'(tv[i].e_stall));
      chk($sformatf("vec%0d_b0", i),    64'(fd_bytes[7:0]), 64'(tv[i].e_b0));
      if (tv[i].e_avail > 0)
        chk($sformatf("vec%0d_pc", i), 64'(fd_pc), 64'(tv[i].e_pc));
    end

    // PC wrap: 40 contiguous bytes across 0xFFFF_FFFF with mixed pops
    cycle(8'h00, '0, 1, 0);
    cycle(8'h00, '0, 1, 0);
    p         = 32'hFFFF_FFF0;
    accepted  = 0;
    seen_high = 1'b0;
    saw_wrap  = 1'b0;
    for (int c = 0; c < 600 && accepted < 40; c++) begin
      cons = 0;
      if (m_avail() > 0) begin
        cons = $urandom_range(1, 8);
        if (cons > m_avail()) cons = m_avail();
      end
      cycle(8'($urandom), p, 0, cons);
      if (m_last_push) begin
        p = p + 32'd1;
        accepted++;
      end
      if (fd_avail != '0 && fd_pc >= 32'hFFFF_FF00) seen_high = 1'b1;
      if (fd_avail != '0 && fd_pc < 32'h100 && seen_high) saw_wrap = 1'b1;
    end
    chk("wrap_accepted", 64'(accepted), 64'd40);
    for (int c = 0; c < 40 && m_q.size() > 0; c++) begin
      cycle(8'h00, 32'h0, 0, m_avail());
      if (fd_avail != '0 && fd_pc < 32'h100 && seen_high) saw_wrap = 1'b1;
    end
    chk("wrap_pc_crossed", 64'(saw_wrap), 64'h1);
    chk("wrap_drained", 64'(fd_avail), 64'h0);

    // Random traffic: contiguous runs, replays, stray PCs, flushes, varied pops
    flush_left = 0;
    p          = 32'($urandom);
    light      = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) light = ~light;
      fl = 1'b0;
      if (flush_left > 0) begin
        fl = 1'b1;
        flush_left--;
      end else if ($urandom_range(0, 49) == 0) begin
        fl         = 1'b1;
        flush_left = LAT - 1;
        p          = 32'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7)      pc = p;
      else if (r < 9) pc = p - 32'($urandom_range(1, 3));
      else            pc = 32'($urandom);
      cons = 0;
      if (m_avail() > 0) begin
        if (!light || $urandom_range(0, 3) == 0) cons = $urandom_range(0, m_avail());
      end
      cycle(8'($urandom), pc, fl, cons);
      if (m_last_push) p = pc + 32'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
